// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scanner: shadow-registered hex value, per-digit blank and dp,
// optional leading-zero suppression, registered active-low outputs with a dark first cycle per dwell.
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]             pre_cnt;
    logic [IW-1:0]             idx;
    logic [4*NUM_DIGITS-1:0]   val_q;
    logic [NUM_DIGITS-1:0]     blank_q;
    logic [NUM_DIGITS-1:0]     dp_q;
    logic                      lz_q;

    logic                      tick;
    logic [NUM_DIGITS-1:0]     supp;
    logic                      upper_zero;
    logic [NUM_DIGITS-1:0]     an_lit;
    logic [3:0]                nib;
    logic                      dark_now;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    assign tick = (pre_cnt == PRE_LAST);

    // Walk from the most significant digit down; digit 0 always stays lit.
    always_comb begin
        supp       = '0;
        upper_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            upper_zero = upper_zero && (val_q[4*k +: 4] == 4'h0);
            supp[k]    = lz_q && upper_zero;
        end
    end

    always_comb begin
        an_lit      = '1;
        an_lit[idx] = 1'b0;
        nib         = val_q[4*idx +: 4];
        dark_now    = blank_q[idx] || supp[idx];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt    <= '0;
            idx        <= '0;
            val_q      <= '0;
            blank_q    <= '1;
            dp_q       <= '0;
            lz_q       <= 1'b0;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            if (load) begin
                val_q   <= value;
                blank_q <= blank_mask;
                dp_q    <= dp_in;
                lz_q    <= lz_en;
            end
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (tick) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
            frame_done <= tick && (idx == IDX_LAST);
            // Blank on the tick so the outgoing digit never bleeds into the next anode.
            if (tick || dark_now) begin
                an  <= '1;
                seg <= 7'h7F;
                dp  <= 1'b1;
            end else begin
                an  <= an_lit;
                seg <= decode(nib);
                dp  <= ~dp_q[idx];
            end
        end
    end
endmodule
